// File: rtl/lfsr_seq_chk_pkg.sv
// rtl/lfsr_seq_chk_pkg.sv - shared types and LFSR step function for the sequence checker
package lfsr_seq_chk_pkg;

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      SYNC   = 2'd1,
      LOCKED = 2'd2
   } chk_state_e;

   // Fibonacci step: parity of the tapped bits shifts in at the top, the rest
   // shift down by one. Operands are zero-extended to 32 bits so any width
   // up to 32 can share this one function.
   function automatic logic [31:0] lfsr_next(input logic [31:0] state,
                                             input logic [31:0] taps,
                                             input int          width);
      logic fb;
      fb = ^(state & taps);
      return (state >> 1) | ({31'd0, fb} << (width - 1));
   endfunction

endpackage

// File: rtl/lfsr_seq_predict.sv
// rtl/lfsr_seq_predict.sv - combinational next-state prediction from the previous sample
module lfsr_seq_predict
   import lfsr_seq_chk_pkg::*;
#(
   parameter int               WIDTH    = 4,
   parameter logic [WIDTH-1:0] TAP_MASK = 4'b0011
) (
   input  logic [WIDTH-1:0] prev,
   output logic [WIDTH-1:0] pred
);

   // Predicted successor of prev, truncated back to the bus width
   always_comb begin
      pred = WIDTH'(lfsr_next(32'(prev), 32'(TAP_MASK), WIDTH));
   end

endmodule

// File: rtl/lfsr_seq_checker.sv
// rtl/lfsr_seq_checker.sv - LFSR state-bus checker with hunt/sync/lock FSM; period measurement under LFSR_SEQ_CHK_PERIOD_EN
module lfsr_seq_checker
   import lfsr_seq_chk_pkg::*;
#(
   parameter int               WIDTH    = 4,
   parameter logic [WIDTH-1:0] TAP_MASK = 4'b0011,
   parameter int               SYNC_LEN = 4,
   parameter int               LOSS_LEN = 3,
   parameter int               CNT_W    = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_state,
   input  logic             clear,
   output logic             locked,
   output logic             err_pulse,
   output logic [CNT_W-1:0] err_count,
   output logic             zero_seen,
   output logic [CNT_W-1:0] period,
   output logic             period_valid
);

   localparam logic [CNT_W-1:0] CNT_ONE   = 1;
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;
   localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_LEN - 1);
   localparam logic [CNT_W-1:0] LOSS_LAST = CNT_W'(LOSS_LEN - 1);

   chk_state_e       state_q, state_d;
   logic [WIDTH-1:0] prev_q, prev_d;
   logic [WIDTH-1:0] pred;
   logic [CNT_W-1:0] match_q, match_d;
   logic [CNT_W-1:0] miss_q, miss_d;
   logic [CNT_W-1:0] err_count_q, err_count_d;
   logic             err_pulse_q, err_pulse_d;
   logic             zero_seen_q, zero_seen_d;
   logic             hit;

`ifdef LFSR_SEQ_CHK_PERIOD_EN
   logic [WIDTH-1:0] ref_state_q, ref_state_d;
   logic [CNT_W-1:0] pcnt_q, pcnt_d;
   logic [CNT_W-1:0] period_q, period_d;
   logic             period_valid_q, period_valid_d;
`endif

   lfsr_seq_predict #(
      .WIDTH    (WIDTH),
      .TAP_MASK (TAP_MASK)
   ) u_predict (
      .prev (prev_q),
      .pred (pred)
   );

   assign hit = (in_state == pred);

   // Next-state: FSM transitions, match/miss run lengths, error bookkeeping
   always_comb begin
      state_d     = state_q;
      prev_d      = prev_q;
      match_d     = match_q;
      miss_d      = miss_q;
      err_count_d = err_count_q;
      err_pulse_d = 1'b0;
      zero_seen_d = zero_seen_q;
`ifdef LFSR_SEQ_CHK_PERIOD_EN
      ref_state_d    = ref_state_q;
      pcnt_d         = pcnt_q;
      period_d       = period_q;
      period_valid_d = 1'b0;
`endif
      if (clear) begin
         // clear wins over a coincident sample; prev and period are kept
         state_d     = HUNT;
         match_d     = '0;
         miss_d      = '0;
         err_count_d = '0;
         zero_seen_d = 1'b0;
`ifdef LFSR_SEQ_CHK_PERIOD_EN
         pcnt_d = '0;
`endif
      end else if (in_valid) begin
         prev_d = in_state;
         if (in_state == '0) begin
            zero_seen_d = 1'b1;
         end
         case (state_q)
            HUNT: begin
               state_d = SYNC;
               match_d = '0;
            end
            SYNC: begin
               if (hit) begin
                  if (match_q == SYNC_LAST) begin
                     state_d = LOCKED;
                     miss_d  = '0;
`ifdef LFSR_SEQ_CHK_PERIOD_EN
                     ref_state_d = in_state;
                     pcnt_d      = '0;
`endif
                  end else begin
                     match_d = match_q + CNT_ONE;
                  end
               end else begin
                  match_d = '0;
               end
            end
            LOCKED: begin
               if (hit) begin
                  miss_d = '0;
               end else begin
                  err_pulse_d = 1'b1;
                  if (err_count_q != CNT_MAX) begin
                     err_count_d = err_count_q + CNT_ONE;
                  end
                  if (miss_q == LOSS_LAST) begin
                     state_d = HUNT;
                  end else begin
                     miss_d = miss_q + CNT_ONE;
                  end
               end
`ifdef LFSR_SEQ_CHK_PERIOD_EN
               // Samples since the lock-entry value last reappeared
               if (in_state == ref_state_q) begin
                  period_d       = (pcnt_q == CNT_MAX) ? CNT_MAX : pcnt_q + CNT_ONE;
                  period_valid_d = 1'b1;
                  pcnt_d         = '0;
               end else if (pcnt_q != CNT_MAX) begin
                  pcnt_d = pcnt_q + CNT_ONE;
               end
`endif
            end
            default: begin
               state_d = HUNT;
            end
         endcase
      end
   end

   // State register with asynchronous reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= HUNT;
         prev_q      <= '0;
         match_q     <= '0;
         miss_q      <= '0;
         err_count_q <= '0;
         err_pulse_q <= 1'b0;
         zero_seen_q <= 1'b0;
`ifdef LFSR_SEQ_CHK_PERIOD_EN
         ref_state_q    <= '0;
         pcnt_q         <= '0;
         period_q       <= '0;
         period_valid_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         prev_q      <= prev_d;
         match_q     <= match_d;
         miss_q      <= miss_d;
         err_count_q <= err_count_d;
         err_pulse_q <= err_pulse_d;
         zero_seen_q <= zero_seen_d;
`ifdef LFSR_SEQ_CHK_PERIOD_EN
         ref_state_q    <= ref_state_d;
         pcnt_q         <= pcnt_d;
         period_q       <= period_d;
         period_valid_q <= period_valid_d;
`endif
      end
   end

   assign locked    = (state_q == LOCKED);
   assign err_pulse = err_pulse_q;
   assign err_count = err_count_q;
   assign zero_seen = zero_seen_q;

`ifdef LFSR_SEQ_CHK_PERIOD_EN
   assign period       = period_q;
   assign period_valid = period_valid_q;
`else
   assign period       = '0;
   assign period_valid = 1'b0;
`endif

endmodule

// File: tb/tb_lfsr_seq_checker.sv
// tb/tb_lfsr_seq_checker.sv - self-checking bench for lfsr_seq_checker against a behavioural model
module tb_lfsr_seq_checker;

   localparam int SYNC_LEN = 4;
   localparam int LOSS_LEN = 3;
`ifdef LFSR_SEQ_CHK_PERIOD_EN
   localparam bit PEN = 1'b1;
`else
   localparam bit PEN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic [3:0] in_state = 4'd0;
   logic       clear = 1'b0;
   logic       locked, err_pulse, zero_seen, period_valid;
   logic [7:0] err_count, period;

   int checks   = 0;
   int failures = 0;

   lfsr_seq_checker dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_state     (in_state),
      .clear        (clear),
      .locked       (locked),
      .err_pulse    (err_pulse),
      .err_count    (err_count),
      .zero_seen    (zero_seen),
      .period       (period),
      .period_valid (period_valid)
   );

   always #5 clk = ~clk;

   logic [3:0] seq [15] = '{4'hF, 4'h7, 4'h3, 4'h1, 4'h8, 4'h4, 4'h2, 4'h9,
                            4'hC, 4'h6, 4'hB, 4'h5, 4'hA, 4'hD, 4'hE};

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   function automatic logic [3:0] m_next(input logic [3:0] p);
      int fb;
      fb = $countones(p & 4'b0011) % 2;
      return 4'((p >> 1) + fb * 8);
   endfunction

   // Behavioural model: mode 0 hunting, 1 syncing, 2 locked
   int         m_mode, m_run, m_miss, m_err, m_period, idx, ref_idx, diff;
   bit         m_zero, m_pulse, m_pv, hit;
   logic [3:0] m_prev, m_ref;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_mode = 0; m_run = 0; m_miss = 0; m_err = 0; m_period = 0;
         idx = 0; ref_idx = 0; m_zero = 0; m_pulse = 0; m_pv = 0;
         m_prev = 4'd0; m_ref = 4'd0;
      end else begin
         m_pulse = 0;
         m_pv    = 0;
         if (clear) begin
            m_mode = 0; m_run = 0; m_miss = 0; m_err = 0; m_zero = 0;
         end else if (in_valid) begin
            idx++;
            hit = (in_state == m_next(m_prev));
            if (in_state == 4'd0) m_zero = 1;
            if (m_mode == 0) begin
               m_mode = 1;
               m_run  = 0;
            end else if (m_mode == 1) begin
               if (hit) begin
                  m_run++;
                  if (m_run == SYNC_LEN) begin
                     m_mode  = 2;
                     m_miss  = 0;
                     m_ref   = in_state;
                     ref_idx = idx;
                  end
               end else begin
                  m_run = 0;
               end
            end else begin
               if (in_state == m_ref) begin
                  diff     = idx - ref_idx;
                  m_period = (diff > 255) ? 255 : diff;
                  m_pv     = 1;
                  ref_idx  = idx;
               end
               if (hit) begin
                  m_miss = 0;
               end else begin
                  m_pulse = 1;
                  if (m_err < 255) m_err++;
                  m_miss++;
                  if (m_miss == LOSS_LEN) m_mode = 0;
               end
            end
            m_prev = in_state;
         end
      end
   end

   // Every-cycle comparison of the DUT against the model
   int pulse_cnt = 0;
   int pv_cnt    = 0;
   always @(negedge clk) begin
      chk("cyc_locked",       int'(locked),       int'(m_mode == 2));
      chk("cyc_err_pulse",    int'(err_pulse),    int'(m_pulse));
      chk("cyc_err_count",    int'(err_count),    m_err);
      chk("cyc_zero_seen",    int'(zero_seen),    int'(m_zero));
      chk("cyc_period",       int'(period),       PEN ? m_period : 0);
      chk("cyc_period_valid", int'(period_valid), PEN ? int'(m_pv) : 0);
      if (err_pulse) pulse_cnt++;
      if (period_valid) pv_cnt++;
   end

   task automatic send(input logic [3:0] s);
      in_valid = 1'b1;
      in_state = s;
      clear    = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      clear    = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic lock_up();
      for (int k = 0; k < 5; k++) send(seq[k]);
   endtask

   int         p0, v0, lock_at, r;
   logic [3:0] g;

   initial begin
      // model pinned against the hand-written sequence table
      chk("model_next_1111", int'(m_next(4'b1111)), 7);
      chk("model_next_0001", int'(m_next(4'b0001)), 8);
      for (int k = 0; k < 15; k++)
         chk("model_seq_table", int'(m_next(seq[k])), int'(seq[(k + 1) % 15]));

      repeat (2) @(negedge clk);
      chk("reset_locked",    int'(locked),    0);
      chk("reset_err_count", int'(err_count), 0);
      chk("reset_zero_seen", int'(zero_seen), 0);
      chk("reset_period",    int'(period),    0);
      rst = 1'b0;

      // 1: lock after five in-sequence samples
      lock_up();
      chk("t1_locked",    int'(locked),    1);
      chk("t1_err_count", int'(err_count), 0);

      // 2: one zero corruption gives two errors, lock retained
      #1 p0 = pulse_cnt;
      send(4'b0000);
      send(seq[6]);
      send(seq[7]);
      #1;
      chk("t2_pulses",    pulse_cnt - p0,  2);
      chk("t2_err_count", int'(err_count), 2);
      chk("t2_zero_seen", int'(zero_seen), 1);
      chk("t2_locked",    int'(locked),    1);
      for (int k = 8; k < 15; k++) send(seq[k]);

      // 3: three mismatches drop lock, then no further counting
      do_reset();
      lock_up();
      send(4'hF);
      send(4'hF);
      chk("t3_locked_after2", int'(locked), 1);
      send(4'hF);
      chk("t3_locked",    int'(locked),    0);
      chk("t3_err_count", int'(err_count), 3);
      send(4'hF);
      send(4'hF);
      chk("t3_err_frozen", int'(err_count), 3);

      // 4: random idle gaps do not change lock point or error count
      do_reset();
      lock_at = -1;
      for (int k = 0; k < 15; k++) begin
         send(seq[k]);
         if (lock_at < 0 && locked) lock_at = k;
         idle($urandom_range(1, 5));
      end
      chk("t4_lock_at",    lock_at,         4);
      chk("t4_err_count",  int'(err_count), 0);
      chk("t4_locked",     int'(locked),    1);

      // 5: period measurement over 16 samples after lock
      do_reset();
      lock_up();
      #1 v0 = pv_cnt;
      for (int k = 0; k < 16; k++) send(seq[(5 + k) % 15]);
      #1;
      chk("t5_period",    int'(period), PEN ? 15 : 0);
      chk("t5_pv_pulses", pv_cnt - v0,  PEN ? 1 : 0);

      // 6: clear with a coincident sample, then async reset mid-lock
      send(4'b0000);
      chk("t6_zero_pre", int'(zero_seen), 1);
      in_valid = 1'b1;
      in_state = 4'b0010;
      clear    = 1'b1;
      @(negedge clk);
      clear    = 1'b0;
      in_valid = 1'b0;
      chk("t6_clear_locked", int'(locked),    0);
      chk("t6_clear_errs",   int'(err_count), 0);
      chk("t6_clear_zero",   int'(zero_seen), 0);
      lock_up();
      send(4'b0000);
      send(4'b0000);
      chk("t6_relocked", int'(locked), 1);
      #2 rst = 1'b1;
      #1;
      chk("t6_rst_locked",       int'(locked),       0);
      chk("t6_rst_err_pulse",    int'(err_pulse),    0);
      chk("t6_rst_err_count",    int'(err_count),    0);
      chk("t6_rst_zero_seen",    int'(zero_seen),    0);
      chk("t6_rst_period",       int'(period),       0);
      chk("t6_rst_period_valid", int'(period_valid), 0);
      @(negedge clk);
      rst = 1'b0;

      // random phase: generator stream with corruption, gaps and clears
      g = 4'hF;
      for (int i = 0; i < 1500; i++) begin
         r = $urandom_range(0, 99);
         if (r < 60) begin
            in_valid = 1'b1; clear = 1'b0; in_state = g; g = m_next(g);
         end else if (r < 70) begin
            in_valid = 1'b1; clear = 1'b0; in_state = 4'($urandom); g = m_next(g);
         end else if (r < 72) begin
            in_valid = 1'($urandom_range(0, 1)); clear = 1'b1; in_state = g;
         end else begin
            in_valid = 1'b0; clear = 1'b0; in_state = 4'($urandom);
         end
         @(negedge clk);
      end
      idle(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
